// File: rtl/park_slot_allocator.sv
// ---------------------------------------------------------------------------
// park_slot_allocator
//
// Clocked parking-lot slot allocator. Keeps an occupancy map of SLOTS spaces,
// reserves the lowest-index free slot on an entry request, offers it to the
// entry gate until grant_ack or a timeout, and frees slots on exit requests.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   enable       block enable; when low, entry/exit requests are ignored
//                and the timeout counter freezes (grant_ack still accepted)
//   entry_req    car at the entry gate requests a slot
//   grant_ack    car passed the entry gate, confirming the offered slot
//   exit_req     car leaving, frees exit_slot
//   exit_slot    index of the slot being vacated
//   grant_valid  a slot is reserved and offered at grant_slot
//   grant_slot   reserved slot index, 0 when grant_valid is low
//   entry_reject one-cycle pulse: entry request while the lot is full
//   exit_error   one-cycle pulse: exit of a free or out-of-range slot
//   free_map     free flags, slot i at bit SLOTS-1-i (slot 0 is the MSB)
//   free_count   number of free slots
//   full         free_count == 0
//   empty        free_count == SLOTS
// ---------------------------------------------------------------------------
module park_slot_allocator #(
    parameter int SLOTS   = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             entry_req,
    input  logic             grant_ack,
    input  logic             exit_req,
    input  logic [IDX_W-1:0] exit_slot,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_slot,
    output logic             entry_reject,
    output logic             exit_error,
    output logic [SLOTS-1:0] free_map,
    output logic [IDX_W:0]   free_count,
    output logic             full,
    output logic             empty
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    // Internally the free vector is indexed by slot number (bit i = slot i);
    // it is bit-reversed onto free_map at the port.
    logic [SLOTS-1:0] free_vec_reg, free_vec_next;
    logic [IDX_W:0]   free_count_reg, free_count_next;
    logic [IDX_W-1:0] grant_slot_reg, grant_slot_next;
    logic [7:0]       timer_reg, timer_next;
    logic             reject_reg, reject_next;
    logic             exit_err_reg, exit_err_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;

    logic [SLOTS-1:0] exit_hit;
    logic [SLOTS-1:0] grant_hit;
    logic [SLOTS-1:0] alloc_hit;
    logic [IDX_W-1:0] first_idx;
    logic             first_found;
    logic             exit_valid;
    logic             exit_invalid;
    logic             alloc;
    logic             rel_slot;

    // One-hot decodes. An out-of-range exit_slot matches no slot, so it can
    // never look occupied and is reported as an exit error.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign exit_hit[gi]            = (exit_slot == IDX_W'(gi));
            assign grant_hit[gi]           = (grant_slot_reg == IDX_W'(gi));
            assign alloc_hit[gi]           = (first_idx == IDX_W'(gi));
            assign free_map[SLOTS-1-gi]    = free_vec_reg[gi];
        end
    endgenerate

    // Lowest-index free slot, taken from the pre-exit map so a slot freed in
    // the same cycle only becomes allocatable on the next one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free_vec_reg[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
        end
    end

    assign exit_valid   = enable && exit_req && (|(exit_hit & ~free_vec_reg));
    assign exit_invalid = enable && exit_req && !(|(exit_hit & ~free_vec_reg));

    always_comb begin
        state_next      = state_reg;
        free_vec_next   = free_vec_reg;
        grant_slot_next = grant_slot_reg;
        timer_next      = timer_reg;
        reject_next     = 1'b0;
        exit_err_next   = exit_invalid;
        alloc           = 1'b0;
        rel_slot        = 1'b0;

        if (exit_valid) begin
            free_vec_next = free_vec_next | exit_hit;
        end

        case (state_reg)
            ST_IDLE: begin
                if (enable && entry_req) begin
                    if (first_found) begin
                        // The exit slot (if any) was occupied, the allocated
                        // slot was free: the two masks never overlap.
                        free_vec_next   = free_vec_next & ~alloc_hit;
                        grant_slot_next = first_idx;
                        timer_next      = 8'(TIMEOUT);
                        alloc           = 1'b1;
                        state_next      = ST_GRANT;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (exit_valid && (exit_slot == grant_slot_reg)) begin
                    // Exit of the reserved slot already freed it above;
                    // just cancel the offer.
                    grant_slot_next = '0;
                    timer_next      = '0;
                    state_next      = ST_IDLE;
                end else if (grant_ack) begin
                    // Ack beats a same-cycle expiry and works while disabled.
                    grant_slot_next = '0;
                    timer_next      = '0;
                    state_next      = ST_IDLE;
                end else if (enable) begin
                    if (timer_reg <= 8'd1) begin
                        free_vec_next   = free_vec_next | grant_hit;
                        rel_slot        = 1'b1;
                        grant_slot_next = '0;
                        timer_next      = '0;
                        state_next      = ST_IDLE;
                    end else begin
                        timer_next = timer_reg - 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        free_count_next = free_count_reg
                        + (IDX_W+1)'(exit_valid)
                        + (IDX_W+1)'(rel_slot)
                        - (IDX_W+1)'(alloc);
        full_next  = (free_count_next == '0);
        empty_next = (free_count_next == (IDX_W+1)'(SLOTS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            free_vec_reg   <= '1;
            free_count_reg <= (IDX_W+1)'(SLOTS);
            grant_slot_reg <= '0;
            timer_reg      <= '0;
            reject_reg     <= 1'b0;
            exit_err_reg   <= 1'b0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
        end else begin
            state_reg      <= state_next;
            free_vec_reg   <= free_vec_next;
            free_count_reg <= free_count_next;
            grant_slot_reg <= grant_slot_next;
            timer_reg      <= timer_next;
            reject_reg     <= reject_next;
            exit_err_reg   <= exit_err_next;
            full_reg       <= full_next;
            empty_reg      <= empty_next;
        end
    end

    assign grant_valid  = (state_reg == ST_GRANT);
    assign grant_slot   = grant_slot_reg;
    assign entry_reject = reject_reg;
    assign exit_error   = exit_err_reg;
    assign free_count   = free_count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;

endmodule

// File: tb/tb_park_slot_allocator.sv
// ---------------------------------------------------------------------------
// tb_park_slot_allocator
//
// Scoreboard bench: each step drives one cycle of stimulus, a behavioural
// model predicts the registered outputs after that edge and pushes them to a
// queue; after the edge the prediction is popped and compared.
// ---------------------------------------------------------------------------
module tb_park_slot_allocator;

    localparam int SLOTS   = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             entry_req;
    logic             grant_ack;
    logic             exit_req;
    logic [IDX_W-1:0] exit_slot;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_slot;
    logic             entry_reject;
    logic             exit_error;
    logic [SLOTS-1:0] free_map;
    logic [IDX_W:0]   free_count;
    logic             full;
    logic             empty;

    park_slot_allocator #(
        .SLOTS  (SLOTS),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .entry_req   (entry_req),
        .grant_ack   (grant_ack),
        .exit_req    (exit_req),
        .exit_slot   (exit_slot),
        .grant_valid (grant_valid),
        .grant_slot  (grant_slot),
        .entry_reject(entry_reject),
        .exit_error  (exit_error),
        .free_map    (free_map),
        .free_count  (free_count),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             gv;
        logic [IDX_W-1:0] gs;
        logic             rej;
        logic             err;
        logic [SLOTS-1:0] map;
        logic [IDX_W:0]   cnt;
        logic             full;
        logic             empty;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state.
    bit m_occ[SLOTS];
    bit m_grant;
    int m_slot;
    int m_timer;
    bit m_rej;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
        m_grant = 1'b0;
        m_slot  = 0;
        m_timer = 0;
        m_rej   = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   nfree;
        nfree = 0;
        e     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            e.map[SLOTS-1-i] = !m_occ[i];
            if (!m_occ[i]) nfree++;
        end
        e.cnt   = (IDX_W+1)'(nfree);
        e.full  = (nfree == 0);
        e.empty = (nfree == SLOTS);
        e.gv    = m_grant;
        e.gs    = m_grant ? IDX_W'(m_slot) : '0;
        e.rej   = m_rej;
        e.err   = m_err;
        return e;
    endfunction

    // One clock of stimulus, model prediction and scoreboard comparison.
    task automatic step(input bit en, input bit entry, input bit ack,
                        input bit ex, input int slot);
        bit   ex_ok;
        bit   snap[SLOTS];
        int   first;
        exp_t e;
        exp_t got;

        ex_ok = en && ex && (slot < SLOTS) && m_occ[slot];
        m_err = en && ex && !ex_ok;
        m_rej = 1'b0;
        snap  = m_occ;
        if (!m_grant) begin
            if (en && entry) begin
                first = -1;
                for (int i = SLOTS - 1; i >= 0; i--) if (!snap[i]) first = i;
                if (first >= 0) begin
                    m_occ[first] = 1'b1;
                    m_grant      = 1'b1;
                    m_slot       = first;
                    m_timer      = TIMEOUT;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end else begin
            if (ex_ok && slot == m_slot) begin
                m_grant = 1'b0;
            end else if (ack) begin
                m_grant = 1'b0;
            end else if (en) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_occ[m_slot] = 1'b0;
                    m_grant       = 1'b0;
                end
            end
        end
        if (ex_ok) m_occ[slot] = 1'b0;
        exp_q.push_back(model_outputs());

        enable    = en;
        entry_req = entry;
        grant_ack = ack;
        exit_req  = ex;
        exit_slot = IDX_W'(slot);
        @(posedge clk);
        #1;
        n_txn++;
        got = {grant_valid, grant_slot, entry_reject, exit_error,
               free_map, free_count, full, empty};
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("grant_valid",  32'(got.gv),    32'(e.gv));
            check("grant_slot",   32'(got.gs),    32'(e.gs));
            check("entry_reject", 32'(got.rej),   32'(e.rej));
            check("exit_error",   32'(got.err),   32'(e.err));
            check("free_map",     32'(got.map),   32'(e.map));
            check("free_count",   32'(got.cnt),   32'(e.cnt));
            check("full",         32'(got.full),  32'(e.full));
            check("empty",        32'(got.empty), 32'(e.empty));
        end
        $display("txn %0d: en=%0b entry=%0b ack=%0b exit=%0b/%0d -> gv=%0b gs=%0d rej=%0b err=%0b map=%b cnt=%0d",
                 n_txn, en, entry, ack, ex, slot, grant_valid, grant_slot,
                 entry_reject, exit_error, free_map, free_count);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_map"},   32'(free_map),    32'hFF);
        check({tag, "_count"}, 32'(free_count),  32'd8);
        check({tag, "_empty"}, 32'(empty),       32'd1);
        check({tag, "_full"},  32'(full),        32'd0);
        check({tag, "_gv"},    32'(grant_valid), 32'd0);
        check({tag, "_gs"},    32'(grant_slot),  32'd0);
        check({tag, "_rej"},   32'(entry_reject),32'd0);
        check({tag, "_err"},   32'(exit_error),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        entry_req = 1'b0;
        grant_ack = 1'b0;
        exit_req  = 1'b0;
        exit_slot = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Fill the lot in order, then a rejected ninth entry.
        for (int i = 0; i < SLOTS; i++) begin
            step(1, 1, 0, 0, 0);
            check("fill_slot", 32'(grant_slot), 32'(i));
            step(1, 0, 1, 0, 0);
        end
        check("full_map", 32'(free_map), 32'h00);
        check("full_flag", 32'(full), 32'd1);
        step(1, 1, 0, 0, 0);
        check("full_reject", 32'(entry_reject), 32'd1);
        step(1, 0, 0, 0, 0);

        // Exit slot 5 from full, then re-allocate it.
        step(1, 0, 0, 1, 5);
        check("exit5_map", 32'(free_map), 32'h04);
        check("exit5_count", 32'(free_count), 32'd1);
        step(1, 1, 0, 0, 0);
        check("realloc5", 32'(grant_slot), 32'd5);
        step(1, 0, 1, 0, 0);

        // Empty the lot, then let a reservation time out.
        for (int i = 0; i < SLOTS; i++) step(1, 0, 0, 1, i);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 0, 0);
        check("timeout_held", 32'(grant_valid), 32'd1);
        step(1, 0, 0, 0, 0);
        check("timeout_drop", 32'(grant_valid), 32'd0);
        check("timeout_count", 32'(free_count), 32'd8);

        // Exit of a free slot, then exit + entry in the same cycle.
        step(1, 0, 0, 1, 3);
        check("bad_exit_err", 32'(exit_error), 32'd1);
        check("bad_exit_map", 32'(free_map), 32'hFF);
        for (int i = 0; i < SLOTS - 1; i++) begin
            step(1, 1, 0, 0, 0);
            step(1, 0, 1, 0, 0);
        end
        step(1, 1, 0, 1, 0);
        check("swap_slot", 32'(grant_slot), 32'd7);
        check("swap_count", 32'(free_count), 32'd1);
        step(1, 0, 1, 0, 0);

        // Disabled during GRANT: no timeout, requests ignored.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, i[0], 0, i[1], i % SLOTS);
        check("disabled_held", 32'(grant_valid), 32'd1);
        step(1, 0, 1, 0, 0);
        check("reenable_map", 32'(free_map), 32'h00);

        // Ack on the expiry cycle wins; exit of the reserved slot cancels.
        for (int i = 0; i < SLOTS; i++) step(1, 0, 0, 1, i);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("ack_wins_map", 32'(free_map), 32'h7F);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1);
        check("cancel_gv", 32'(grant_valid), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, SLOTS - 1)));
        end

        // Asynchronous reset in the middle of a GRANT with 3 slots used.
        for (int i = 0; i < SLOTS; i++) step(1, 0, 0, 1, i);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 0);
            step(1, 0, 1, 0, 0);
        end
        step(1, 1, 0, 0, 0);
        check("pre_reset_gv", 32'(grant_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 1, 0, 0, 0);
        check("post_reset_slot", 32'(grant_slot), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
